button_debounce_multi: RTL and testbench
========================================

Name: button_debounce_multi

Overview:
- Parametrised N-channel push-button debouncer for board buttons.
- Each channel has per-channel input polarity, a 2-flop synchroniser, a debounce counter, and registered press/release pulses.
- Optional auto-repeat (typematic) pulse generator per channel.
- Feeds UI/menu logic and PS/2-style keyboard emulation, which need held-key repeat.

Parameters:
- N, 7, number of button channels.
- CNT_W, 16, debounce counter width; input must be stable for 2^CNT_W cycles.
- ACTIVE_LOW, 7'b0000001, bit i = 1 means btn_in[i] is active-low (inverted on entry).
- REPEAT_MASK, 7'b1111110, bit i = 1 enables auto-repeat on channel i.
- RPT_W, 24, repeat counter width.
- REPEAT_FIRST, 24'd12_500_000, cycles from press pulse to first repeat pulse; must be ≥2.
- REPEAT_RATE, 24'd2_500_000, cycles between subsequent repeat pulses; must be ≥2.

Ports:
- clk, input, 1, system clock.
- resetn, input, 1, asynchronous active-low reset.
- btn_in, input, N, raw asynchronous button pins.
- btn_state, output, N, debounced level, active-high (1 = pressed).
- btn_down, output, N, one-cycle pulse on debounced press.
- btn_up, output, N, one-cycle pulse on debounced release.
- btn_repeat, output, N, one-cycle pulse on press and on every auto-repeat tick.

Behaviour:
- Reset (resetn low, async): sync flops, counters, btn_state, btn_down, btn_up and btn_repeat all 0; repeat FSMs go to IDLE. Release is synchronous to clk.
- Normalise per channel: n[i] = btn_in[i] ^ ACTIVE_LOW[i]. Synchronise with s0 <= n, s1 <= s0.
- idle[i] = (btn_state[i] == s1[i]).
  - idle: cnt <= 0.
  - not idle and cnt != max: cnt <= cnt + 1.
  - not idle and cnt == all-ones: btn_state toggles, cnt <= 0, and the matching btn_down or btn_up pulse is asserted at the same edge.
- All outputs are registered. btn_down and btn_state rise on the same edge. Pulses last exactly one cycle.
- Latency: pin stable before edge E0 gives the state change at edge E0 + 2 + 2^CNT_W.
- Any bounce that returns s1 to btn_state before the counter maxes clears cnt, and no output changes.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Repeat FSM per channel, states IDLE, DELAY, REPEAT, with counter rc (RPT_W bits):
  - IDLE: on debounced press, btn_repeat pulses together with btn_down. If REPEAT_MASK[i] is set, go to DELAY with rc <= 0; otherwise stay in IDLE.
  - DELAY: rc increments each cycle. At rc == REPEAT_FIRST-1: btn_repeat pulses, rc <= 0, go to REPEAT. First repeat pulse is REPEAT_FIRST cycles after the press pulse.
  - REPEAT: at rc == REPEAT_RATE-1: pulse, rc <= 0, stay in REPEAT. Pulse spacing is REPEAT_RATE cycles.
  - In DELAY or REPEAT, a debounced release goes to IDLE and rc <= 0. No btn_repeat pulse occurs on that edge, even if rc would hit its terminal value that cycle (release wins).
- Masked-off channel: btn_repeat[i] == btn_down[i].
- Reset mid-press: everything clears. A still-held button is re-detected as a fresh press after full debounce latency.

Test Plan (N=2, CNT_W=4, ACTIVE_LOW=2'b01, REPEAT_MASK=2'b10, REPEAT_FIRST=40, REPEAT_RATE=10):
- Reset, btn_in=2'b01 (both released) held for 100 cycles -> all outputs stay 0 with no pulses.
- Drive btn_in[1]=1 cleanly at edge E0 -> btn_state[1] and btn_down[1] rise at E0+18; btn_down[1] is high for exactly 1 cycle.
- Bounce btn_in[1] high for 10 cycles, low for 3, then high and stable -> one btn_down[1] only, 18 cycles after the final rising edge; no btn_up.
- Hold btn_in[1] for 100 cycles after press -> btn_repeat[1] pulses at P, P+40, P+50, P+60, ... (P = press pulse). Release -> btn_up[1] 18 cycles later and repeats stop.
- Drive btn_in[0]=0 (active-low press) and btn_in[1]=1 on the same edge -> btn_down=2'b11 in the same cycle. Ch0 btn_repeat mirrors btn_down only, with no repeats while held.
- Hold ch1, assert resetn low mid-REPEAT for 3 cycles -> outputs clear immediately (async); after release, btn_down[1] reappears 18 cycles after resetn deassertion.

Source files
------------

// File: rtl/button_debounce_multi.sv
// N-channel push-button debouncer: per-channel polarity, 2-flop synchroniser,
// saturating debounce counter, registered press/release pulses and typematic repeat.
module button_debounce_multi #(
    parameter int               N            = 7,
    parameter int               CNT_W        = 16,
    parameter logic [N-1:0]     ACTIVE_LOW   = 7'b0000001,
    parameter logic [N-1:0]     REPEAT_MASK  = 7'b1111110,
    parameter int               RPT_W        = 24,
    parameter logic [RPT_W-1:0] REPEAT_FIRST = 24'd12_500_000,
    parameter logic [RPT_W-1:0] REPEAT_RATE  = 24'd2_500_000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_state,
    output logic [N-1:0] btn_down,
    output logic [N-1:0] btn_up,
    output logic [N-1:0] btn_repeat
);

    localparam logic [RPT_W-1:0] FIRST_LAST = REPEAT_FIRST - 1'b1;
    localparam logic [RPT_W-1:0] RATE_LAST  = REPEAT_RATE - 1'b1;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic             s0_q, s1_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             state_q, state_d;
        logic             down_q, up_q, rep_q;
        rpt_state_e       rpt_q;
        logic [RPT_W-1:0] rc_q;

        logic idle, cnt_max, toggle, press_evt, release_evt;

        assign idle        = (state_q == s1_q);
        assign cnt_max     = &cnt_q;
        assign toggle      = !idle && cnt_max;
        assign press_evt   = toggle && !state_q;
        assign release_evt = toggle && state_q;

        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        always_comb begin
            cnt_d   = cnt_q;
            state_d = state_q;
            if (idle) begin
                cnt_d = '0;
            end else if (cnt_max) begin
                cnt_d   = '0;
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; reset is asynchronous, release is synchronous.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                s0_q    <= 1'b0;
                s1_q    <= 1'b0;
                cnt_q   <= '0;
                state_q <= 1'b0;
                down_q  <= 1'b0;
                up_q    <= 1'b0;
            end else begin
                s0_q    <= btn_in[i] ^ ACTIVE_LOW[i];
                s1_q    <= s0_q;
                cnt_q   <= cnt_d;
                state_q <= state_d;
                down_q  <= press_evt;
                up_q    <= release_evt;
            end
        end

        // Typematic FSM; a release on the same edge as a terminal count wins.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                rpt_q <= RPT_IDLE;
                rc_q  <= '0;
                rep_q <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                unique case (rpt_q)
                    RPT_IDLE: begin
                        if (press_evt) begin
                            rep_q <= 1'b1;
                            rc_q  <= '0;
                            if (REPEAT_MASK[i]) begin
                                rpt_q <= RPT_DELAY;
                            end
                        end
                    end
                    RPT_DELAY: begin
                        if (release_evt) begin
                            rpt_q <= RPT_IDLE;
                            rc_q  <= '0;
                        end else if (rc_q == FIRST_LAST) begin
                            rep_q <= 1'b1;
                            rc_q  <= '0;
                            rpt_q <= RPT_REPEAT;
                        end else begin
                            rc_q <= rc_q + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (release_evt) begin
                            rpt_q <= RPT_IDLE;
                            rc_q  <= '0;
                        end else if (rc_q == RATE_LAST) begin
                            rep_q <= 1'b1;
                            rc_q  <= '0;
                        end else begin
                            rc_q <= rc_q + 1'b1;
                        end
                    end
                    default: begin
                        rpt_q <= RPT_IDLE;
                        rc_q  <= '0;
                    end
                endcase
            end
        end

        assign btn_state[i]  = state_q;
        assign btn_down[i]   = down_q;
        assign btn_up[i]     = up_q;
        assign btn_repeat[i] = rep_q;
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Scoreboard bench for button_debounce_multi: expected pulse events are queued
// as stimulus is driven and matched against observed pulses on the falling edge.
module tb_button_debounce_multi;

    localparam int               N            = 2;
    localparam int               CNT_W        = 4;
    localparam int               RPT_W        = 8;
    localparam logic [N-1:0]     ACTIVE_LOW   = 2'b01;
    localparam logic [N-1:0]     REPEAT_MASK  = 2'b10;
    localparam logic [RPT_W-1:0] REPEAT_FIRST = 8'd40;
    localparam logic [RPT_W-1:0] REPEAT_RATE  = 8'd10;

    localparam int LAT   = 18;   // pin change after edge E0 -> state change at E0+18
    localparam int FIRST = 40;
    localparam int RATE  = 10;

    localparam int EV_DOWN = 0;
    localparam int EV_UP   = 1;
    localparam int EV_REP  = 2;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] btn_in = 2'b01;
    logic [N-1:0] btn_state, btn_down, btn_up, btn_repeat;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    button_debounce_multi #(
        .N           (N),
        .CNT_W       (CNT_W),
        .ACTIVE_LOW  (ACTIVE_LOW),
        .REPEAT_MASK (REPEAT_MASK),
        .RPT_W       (RPT_W),
        .REPEAT_FIRST(REPEAT_FIRST),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .btn_in    (btn_in),
        .btn_state (btn_state),
        .btn_down  (btn_down),
        .btn_up    (btn_up),
        .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic string kind_name(input int k);
        case (k)
            EV_DOWN: return "down";
            EV_UP:   return "up";
            default: return "repeat";
        endcase
    endfunction

    // Every observed pulse pops the oldest expected event and must match it.
    always @(negedge clk) begin : monitor
        ev_t  e;
        logic b;
        if (mon_en) begin
            for (int ch = 0; ch < N; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    b = (k == EV_DOWN) ? btn_down[ch] : (k == EV_UP) ? btn_up[ch] : btn_repeat[ch];
                    if (b === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_pulse: got %s ch%0d at cycle %0d, expected no pulse",
                                     kind_name(k), ch, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.cyc !== cyc || e.ch !== ch || e.kind !== k) begin
                                errors++;
                                $display("FAIL pulse_match: got %s ch%0d at cycle %0d, expected %s ch%0d at cycle %0d",
                                         kind_name(k), ch, cyc, kind_name(e.kind), e.ch, e.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int c, input int ch, input int kind);
        ev_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // Changes the pins just after an edge; e_cyc is that edge's number.
    task automatic drive(input logic [N-1:0] v, output int e_cyc);
        @(posedge clk);
        #1;
        btn_in = v;
        e_cyc  = cyc;
    endtask

    // Returns at the falling edge that follows rising edge number c.
    task automatic wait_neg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset;
        int t0;
        resetn = 1'b0;
        btn_in = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({btn_state, btn_down, btn_up, btn_repeat} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {btn_state, btn_down, btn_up, btn_repeat});
        end
        resetn = 1'b1;
        mon_en = 1'b1;
        t0 = cyc;
        wait_neg(t0 + 100);
        checks++;
        if (btn_state !== 2'b00) begin
            errors++;
            $display("FAIL idle_state: got %b expected 00", btn_state);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_drain: got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_press_hold_repeat;
        int e0, p, r, rel;
        drive(2'b11, e0);
        p = e0 + LAT;
        r = p + 102;               // release lands on the would-be P+120 repeat edge
        push(p, 1, EV_DOWN);
        push(p, 1, EV_REP);
        for (int t = p + FIRST; t < r + LAT; t += RATE) push(t, 1, EV_REP);
        wait_neg(p - 1);
        checks++;
        if (btn_state[1] !== 1'b0) begin
            errors++;
            $display("FAIL press_early: got %b expected 0", btn_state[1]);
        end
        wait_neg(p);
        checks++;
        if (btn_state[1] !== 1'b1 || btn_down[1] !== 1'b1) begin
            errors++;
            $display("FAIL press_edge: got state=%b down=%b expected 1 1", btn_state[1], btn_down[1]);
        end
        wait_neg(r - 1);
        drive(2'b01, rel);
        push(rel + LAT, 1, EV_UP);
        wait_neg(rel + LAT);
        checks++;
        if (btn_state[1] !== 1'b0 || btn_repeat[1] !== 1'b0) begin
            errors++;
            $display("FAIL release_edge: got state=%b repeat=%b expected 0 0", btn_state[1], btn_repeat[1]);
        end
        wait_neg(rel + LAT + 60);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_drain: got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce;
        int e0, e1, e2, er;
        drive(2'b11, e0);
        wait_neg(e0 + 9);
        drive(2'b01, e1);
        wait_neg(e1 + 2);
        drive(2'b11, e2);
        push(e2 + LAT, 1, EV_DOWN);
        push(e2 + LAT, 1, EV_REP);
        wait_neg(e2 + LAT - 1);
        checks++;
        if (btn_state[1] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_early: got %b expected 0", btn_state[1]);
        end
        wait_neg(e2 + 19);
        drive(2'b01, er);
        push(er + LAT, 1, EV_UP);
        wait_neg(er + LAT + 10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_drain: got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_simultaneous;
        int e0, e1, e2, p;
        drive(2'b10, e0);
        p = e0 + LAT;
        push(p, 0, EV_DOWN);
        push(p, 0, EV_REP);
        push(p, 1, EV_DOWN);
        push(p, 1, EV_REP);
        wait_neg(p);
        checks++;
        if (btn_down !== 2'b11 || btn_repeat !== 2'b11) begin
            errors++;
            $display("FAIL simul_pulse: got down=%b repeat=%b expected 11 11", btn_down, btn_repeat);
        end
        wait_neg(e0 + 24);
        drive(2'b00, e1);
        push(e1 + LAT, 1, EV_UP);
        wait_neg(e0 + 99);
        checks++;
        if (btn_state !== 2'b01) begin
            errors++;
            $display("FAIL simul_hold: got %b expected 01", btn_state);
        end
        drive(2'b01, e2);
        push(e2 + LAT, 0, EV_UP);
        wait_neg(e2 + LAT + 10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL simul_drain: got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_repeat;
        int e0, p, d, er;
        drive(2'b11, e0);
        p = e0 + LAT;
        push(p, 1, EV_DOWN);
        push(p, 1, EV_REP);
        push(p + FIRST, 1, EV_REP);
        push(p + FIRST + RATE, 1, EV_REP);
        wait_neg(p + 55);
        checks++;
        if (btn_state !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_state: got %b expected 10", btn_state);
        end
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if ({btn_state, btn_down, btn_up, btn_repeat} !== '0) begin
            errors++;
            $display("FAIL async_clear: got %b expected 0", {btn_state, btn_down, btn_up, btn_repeat});
        end
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        d = cyc;
        push(d + LAT, 1, EV_DOWN);
        push(d + LAT, 1, EV_REP);
        wait_neg(d + LAT - 1);
        checks++;
        if (btn_state !== 2'b00) begin
            errors++;
            $display("FAIL redetect_early: got %b expected 00", btn_state);
        end
        wait_neg(d + 19);
        drive(2'b01, er);
        push(er + LAT, 1, EV_UP);
        wait_neg(er + LAT + 10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_press_hold_repeat();
        test_bounce();
        test_simultaneous();
        test_reset_mid_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
